sdram_stub_responder: RTL and testbench
=======================================

# sdram_stub_responder

Memory-side responder for the 24-bit-address / 32-bit-data DRAM request protocol that the bus arbiter drives. It is a drop-in replacement for the SDRAM controller in simulation and small FPGA builds. It answers read and write requests from an on-chip word array with programmable, deterministic latency. It sits directly below the bus arbiter and exposes no DRAM pins.

## Interface
- `ADDR_BITS`, default 12: implemented word-address bits; array depth is 2^ADDR_BITS words.
- `READ_LATENCY`, default 4: cycles from request acceptance to the `data_valid` pulse; range 1–15.
- `WRITE_LATENCY`, default 3: cycles from request acceptance to the `write_complete` pulse; range 1–15.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `address` in 24: word address; only bits [ADDR_BITS-1:0] are used, so upper bits alias.
- `req_read` in 1: read request, level, held until the response.
- `req_write` in 1: write request, level, held until the response.
- `data_in` in 32: write data, stable while `req_write` is high.
- `data_out` out 32: read data, valid when `data_valid` is high and held until the next read completes.
- `data_valid` out 1: one-cycle read-response pulse.
- `write_complete` out 1: one-cycle write-response pulse.
- `busy` out 1: high in every state except IDLE.
- `protocol_err` out 1: sticky flag; cleared only by reset.

## Operation
- States:
  - IDLE: if `req_write` is high, latch `address` and `data_in`, load the counter with WRITE_LATENCY-1, go to WRITE_WAIT. Else if `req_read` is high, latch `address`, load the counter with READ_LATENCY-1, go to READ_WAIT.
  - READ_WAIT: when the counter reaches 0, drive `data_out` from the array, pulse `data_valid`, go to RELEASE. Otherwise decrement.
  - WRITE_WAIT: when the counter reaches 0, commit the word to the array, pulse `write_complete`, go to RELEASE. Otherwise decrement.
  - RELEASE: stay until `req_read` and `req_write` are both sampled low, then go to IDLE. A held request is therefore never served twice.
- Arbitration and errors:
  - `req_read` and `req_write` both high in IDLE: the write wins and `protocol_err` is set. The read is dropped and must be re-issued.
  - `address` or `data_in` changing while in a WAIT state: ignored, because the values were latched at acceptance.
  - A request dropping during a WAIT state: the transaction still completes and responds, and `protocol_err` is set.
- Array:
  - Memory contents are not reset; simulation initial contents are 0.
  - The write commits only in the `write_complete` cycle, so reset during WRITE_WAIT leaves the array unchanged.
- Reset values:
  - State is IDLE and the counter is 0.
  - `data_out` = 0, `data_valid` = 0, `write_complete` = 0, `busy` = 0, `protocol_err` = 0.
  - Reset asserted mid-transaction aborts it with no response pulse.

## Timing
- Acceptance occurs at edge E0 with the FSM in IDLE and a request high.
- `data_valid` is high for exactly the one cycle after edge E0+READ_LATENCY.
- `write_complete` is high for exactly the one cycle after edge E0+WRITE_LATENCY.
- The earliest next acceptance is two edges after the response edge: one edge to observe the requests low in RELEASE, then IDLE samples.
- Back-to-back throughput is one transaction per LATENCY+2 cycles, assuming the requester drops its request in the response cycle.
- Counter is 4 bits wide and never wraps: a load of 0 responds on the next edge.
- Read-during-write is impossible: the FSM is single-transaction and the array is single-port.

## Structure
- Shared package `d16_mem_pkg` holds:
  - `MEM_ADDR_W` = 24 and `MEM_DATA_W` = 32.
  - The state enum (IDLE, READ_WAIT, WRITE_WAIT, RELEASE).
  - The LATENCY range limits.
- One sub-module, `stub_mem_array`: single-port synchronous RAM, 2^ADDR_BITS × 32, one write enable, registered read. The FSM issues the array read one cycle before the response so the registered output meets the response cycle.
- The FSM, counter and latches live in the top module.

## Test plan
- Write then read: write 0xDEADBEEF to 0x000010 with WRITE_LATENCY=3 → `write_complete` pulses 3 cycles after acceptance. A following read of 0x000010 → `data_valid` pulses 4 cycles after acceptance with `data_out`=0xDEADBEEF, held afterwards.
- Aliasing: write 0x12345678 to 0x001005 with ADDR_BITS=12 → a read of 0x000005 returns 0x12345678.
- Held request: `req_read` held high for 20 cycles → exactly one `data_valid` pulse and `busy` stays high until the request drops; the next request is accepted 2 edges after it drops.
- Simultaneous requests: `req_read` and `req_write` both high with `data_in`=0xA5A5A5A5 → write performed, one `write_complete`, no `data_valid`, `protocol_err`=1 until reset.
- Reset mid-write: assert `rst_n`=0 at WRITE_WAIT count 1 → all outputs are 0 immediately, no pulse, and a later read shows the old word unchanged.
- Latency corner: READ_LATENCY=1 and WRITE_LATENCY=1 → each response arrives in the cycle right after acceptance; repeat with both at 15.

Source files
------------

// File: rtl/d16_mem_pkg.sv
// d16_mem_pkg
//   Shared definitions for the 24-bit-address / 32-bit-data DRAM request
//   protocol: bus widths, responder FSM states and latency limits.
package d16_mem_pkg;

    localparam int MEM_ADDR_W = 24;
    localparam int MEM_DATA_W = 32;

    // Latency counter is 4 bits, so 15 is the longest programmable latency.
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        RELEASE
    } mem_state_t;

    // Counter load value for a latency: the response fires on the edge
    // where the counter is already 0, hence latency-1. Out-of-range
    // latencies are clamped so the counter can never wrap.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        int l;
        l = (lat < LAT_MIN) ? LAT_MIN : ((lat > LAT_MAX) ? LAT_MAX : lat);
        return CNT_W'(l - 1);
    endfunction

endpackage

// File: rtl/stub_mem_array.sv
// stub_mem_array
//   Single-port synchronous RAM, 2^ADDR_BITS x 32, registered read.
//   Ports:
//     clk    - clock
//     we     - write enable, writes wdata to addr
//     re     - read enable, loads rdata from addr on the next edge
//     addr   - word address (shared by read and write)
//     wdata  - write data
//     rdata  - registered read data, holds between reads
//   Contents are not reset.
module stub_mem_array
    import d16_mem_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [MEM_DATA_W-1:0] wdata,
    output logic [MEM_DATA_W-1:0] rdata
);

    logic [MEM_DATA_W-1:0] mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/sdram_stub_responder.sv
// sdram_stub_responder
//   Memory-side stand-in for the SDRAM controller: serves one read or write
//   at a time from an on-chip word array with fixed, programmable latency.
//   Ports:
//     clk, rst_n      - clock, asynchronous active-low reset
//     address         - word address, only [ADDR_BITS-1:0] used (upper bits alias)
//     req_read        - read request level, held until the response
//     req_write       - write request level, held until the response
//     data_in         - write data
//     data_out        - read data, held until the next read completes
//     data_valid      - one-cycle read response pulse
//     write_complete  - one-cycle write response pulse
//     busy            - FSM not in IDLE
//     protocol_err    - sticky: simultaneous requests or a request dropped mid-wait
module sdram_stub_responder
    import d16_mem_pkg::*;
#(
    parameter int ADDR_BITS     = 12,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MEM_ADDR_W-1:0] address,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [MEM_DATA_W-1:0] data_in,
    output logic [MEM_DATA_W-1:0] data_out,
    output logic                  data_valid,
    output logic                  write_complete,
    output logic                  busy,
    output logic                  protocol_err
);

    localparam logic [CNT_W-1:0] RD_LOAD = lat_load(READ_LATENCY);
    localparam logic [CNT_W-1:0] WR_LOAD = lat_load(WRITE_LATENCY);

    mem_state_t             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [MEM_DATA_W-1:0]  wdata_q;
    logic [MEM_DATA_W-1:0]  rdata;
    logic                   accept_rd, accept_wr;
    logic                   rd_done, wr_done;
    logic                   err_set;
    logic                   mem_re;
    logic [ADDR_BITS-1:0]   mem_addr;

    // Upper address bits alias by design.
    logic addr_unused;
    assign addr_unused = ^address[MEM_ADDR_W-1:ADDR_BITS];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept_rd = 1'b0;
        accept_wr = 1'b0;
        rd_done   = 1'b0;
        wr_done   = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                // Write wins a tie; the read is dropped and flagged.
                if (req_write) begin
                    accept_wr = 1'b1;
                    err_set   = req_read;
                    cnt_nxt   = WR_LOAD;
                    state_nxt = WRITE_WAIT;
                end else if (req_read) begin
                    accept_rd = 1'b1;
                    cnt_nxt   = RD_LOAD;
                    state_nxt = READ_WAIT;
                end
            end
            READ_WAIT: begin
                err_set = ~req_read;
                if (cnt == '0) begin
                    rd_done   = 1'b1;
                    state_nxt = RELEASE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            WRITE_WAIT: begin
                err_set = ~req_write;
                if (cnt == '0) begin
                    wr_done   = 1'b1;
                    state_nxt = RELEASE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RELEASE: begin
                // Wait for the requester to let go so a held level is not re-served.
                if (!req_read && !req_write) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The array read is registered, so launch it on the edge before the
    // response edge: whenever the FSM is about to sit in READ_WAIT with a
    // zero count. For READ_LATENCY=1 that is the acceptance edge itself,
    // which is why the address comes straight from the port in IDLE.
    assign mem_re   = (state_nxt == READ_WAIT) && (cnt_nxt == '0);
    assign mem_addr = (state == IDLE) ? address[ADDR_BITS-1:0] : addr_q;

    stub_mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk   (clk),
        .we    (wr_done),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            data_out       <= '0;
            data_valid     <= 1'b0;
            write_complete <= 1'b0;
            protocol_err   <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            if (accept_rd || accept_wr) addr_q <= address[ADDR_BITS-1:0];
            if (accept_wr) wdata_q <= data_in;
            if (rd_done) data_out <= rdata;
            data_valid     <= rd_done;
            write_complete <= wr_done;
            if (err_set) protocol_err <= 1'b1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sdram_stub_responder.sv
// tb_sdram_stub_responder
//   Three responders (default latencies, both latencies 1, both 15) share a
//   clock and reset. Stimulus pushes the expected response (dut, kind, cycle,
//   data) into a scoreboard; a negedge monitor pops and compares on every
//   data_valid / write_complete pulse.
module tb_sdram_stub_responder;

    typedef struct {
        int          dut;
        bit          wr;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    logic        rr   [3];
    logic        rw   [3];
    logic [23:0] addr [3];
    logic [31:0] din  [3];
    logic [31:0] dout [3];
    logic        dv   [3];
    logic        wc   [3];
    logic        bsy  [3];
    logic        perr [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdram_stub_responder #(.ADDR_BITS(12), .READ_LATENCY(4), .WRITE_LATENCY(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .address(addr[0]), .req_read(rr[0]), .req_write(rw[0]),
        .data_in(din[0]), .data_out(dout[0]), .data_valid(dv[0]), .write_complete(wc[0]),
        .busy(bsy[0]), .protocol_err(perr[0]));

    sdram_stub_responder #(.ADDR_BITS(12), .READ_LATENCY(1), .WRITE_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .address(addr[1]), .req_read(rr[1]), .req_write(rw[1]),
        .data_in(din[1]), .data_out(dout[1]), .data_valid(dv[1]), .write_complete(wc[1]),
        .busy(bsy[1]), .protocol_err(perr[1]));

    sdram_stub_responder #(.ADDR_BITS(12), .READ_LATENCY(15), .WRITE_LATENCY(15)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .address(addr[2]), .req_read(rr[2]), .req_write(rw[2]),
        .data_in(din[2]), .data_out(dout[2]), .data_valid(dv[2]), .write_complete(wc[2]),
        .busy(bsy[2]), .protocol_err(perr[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (dv[d] === 1'b1 || wc[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("pulse_expected", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_dut", d, e.dut);
                    chk("resp_kind", {dv[d], wc[d]}, {~e.wr, e.wr});
                    chk("resp_cycle", cyc, e.cyc);
                    if (!e.wr) chk("rd_data", dout[d], e.data);
                end
            end
        end
    end

    // One transaction: raise at a negedge, accepted at the following posedge,
    // drop in the response cycle (or right after acceptance when early=1).
    task automatic do_txn(input int d, input bit wr, input bit both, input bit early,
                          input logic [23:0] a, input logic [31:0] wd,
                          input logic [31:0] rd_exp, input int lat);
        exp_t e;
        bit   got;
        @(negedge clk);
        addr[d] = a;
        din[d]  = wd;
        rw[d]   = wr;
        rr[d]   = ~wr | both;
        @(posedge clk);
        #1;
        e.dut  = d;
        e.wr   = wr;
        e.cyc  = cyc + lat;
        e.data = rd_exp;
        sb.push_back(e);
        if (early) begin
            @(negedge clk);
            rr[d] = 1'b0;
            rw[d] = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = dv[d] | wc[d];
        end
        chk("resp_arrived", got, 1);
        rr[d] = 1'b0;
        rw[d] = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   npulse;
        for (int d = 0; d < 3; d++) begin
            rr[d] = 1'b0; rw[d] = 1'b0; addr[d] = '0; din[d] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_data_out", dout[d], 0);
            chk("rst_data_valid", dv[d], 0);
            chk("rst_write_complete", wc[d], 0);
            chk("rst_busy", bsy[d], 0);
            chk("rst_protocol_err", perr[d], 0);
        end
        rst_n = 1'b1;

        // Write then read, default latencies.
        do_txn(0, 1, 0, 0, 24'h000010, 32'hDEADBEEF, 32'h0, 3);
        do_txn(0, 0, 0, 0, 24'h000010, 32'h0, 32'hDEADBEEF, 4);
        repeat (3) @(negedge clk);
        chk("rd_hold", dout[0], 32'hDEADBEEF);
        chk("idle_busy", bsy[0], 0);

        // Aliasing: bit 12 is beyond ADDR_BITS.
        do_txn(0, 1, 0, 0, 24'h001005, 32'h12345678, 32'h0, 3);

        // Held read for 20 cycles: one pulse, busy held, no error.
        @(negedge clk);
        addr[0] = 24'h000010;
        rr[0]   = 1'b1;
        @(posedge clk);
        #1;
        e = '{dut: 0, wr: 1'b0, cyc: cyc + 4, data: 32'hDEADBEEF};
        sb.push_back(e);
        npulse = 0;
        repeat (20) begin
            @(negedge clk);
            if (dv[0]) npulse++;
        end
        chk("held_busy", bsy[0], 1);
        chk("held_pulses", npulse, 1);
        chk("held_err", perr[0], 0);
        rr[0] = 1'b0;
        // Next request accepted two edges after the drop; also checks aliasing.
        do_txn(0, 0, 0, 0, 24'h000005, 32'h0, 32'h12345678, 4);

        // Simultaneous requests: write wins, error is sticky.
        do_txn(0, 1, 1, 0, 24'h000020, 32'hA5A5A5A5, 32'h0, 3);
        @(negedge clk);
        chk("both_err", perr[0], 1);
        do_txn(0, 0, 0, 0, 24'h000020, 32'h0, 32'hA5A5A5A5, 4);
        chk("both_err_sticky", perr[0], 1);

        // Reset at WRITE_WAIT count 1: abort, outputs clear, array untouched.
        @(negedge clk);
        addr[0] = 24'h000020;
        din[0]  = 32'h11111111;
        rw[0]   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy", bsy[0], 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data_out", dout[0], 0);
        chk("mid_rst_busy", bsy[0], 0);
        chk("mid_rst_err", perr[0], 0);
        chk("mid_rst_wc", wc[0], 0);
        rw[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        do_txn(0, 0, 0, 0, 24'h000020, 32'h0, 32'hA5A5A5A5, 4);

        // Latency 1 corner.
        do_txn(1, 1, 0, 0, 24'h000003, 32'hCAFEF00D, 32'h0, 1);
        do_txn(1, 0, 0, 0, 24'h000003, 32'h0, 32'hCAFEF00D, 1);
        chk("lat1_err", perr[1], 0);

        // Latency 15 corner, then a read dropped mid-wait.
        do_txn(2, 1, 0, 0, 24'h0007FF, 32'h0BADC0DE, 32'h0, 15);
        do_txn(2, 0, 0, 0, 24'h0007FF, 32'h0, 32'h0BADC0DE, 15);
        chk("lat15_err", perr[2], 0);
        do_txn(2, 0, 0, 1, 24'h0007FF, 32'h0, 32'h0BADC0DE, 15);
        @(negedge clk);
        chk("drop_err", perr[2], 1);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
